// File: rtl/cp0_tlb_regs_if.sv
// cp0_tlb_regs_if
//   Bundles the M-stage MTC0/MFC0 port, the TLB op/result port and the
//   exception-address port of the CP0 MMU register slice.
//
//   master : pipeline/TLB side (drives strobes, addresses and TLB results)
//   slave  : cp0_tlb_regs (drives read data and the registered TLB inputs)
//
//   mtc0_we/mtc0_addr/mtc0_wdata : MTC0 write strobe, register number, data
//   mfc0_addr/mfc0_rdata         : MFC0 register number, read data
//   tlb_type                     : 001 TLBP, 010 TLBR, 011 TLBWI, 100 TLBWR
//   tlbp_index_in, tlbr_*_in     : TLBP/TLBR results from the TLB array
//   tlb_exc/exc_vaddr            : TLB exception commit and faulting address
//   entryhi..random              : registered values driven to the TLB
interface cp0_tlb_regs_if;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [2:0]  tlb_type;
    logic [31:0] tlbp_index_in;
    logic [31:0] tlbr_entryhi_in;
    logic [31:0] tlbr_pagemask_in;
    logic [31:0] tlbr_entrylo0_in;
    logic [31:0] tlbr_entrylo1_in;
    logic        tlb_exc;
    logic [31:0] exc_vaddr;
    logic [31:0] entryhi;
    logic [31:0] pagemask;
    logic [31:0] entrylo0;
    logic [31:0] entrylo1;
    logic [31:0] index;
    logic [31:0] random;

    modport master (
        output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, tlb_type,
        output tlbp_index_in, tlbr_entryhi_in, tlbr_pagemask_in,
        output tlbr_entrylo0_in, tlbr_entrylo1_in, tlb_exc, exc_vaddr,
        input  mfc0_rdata, entryhi, pagemask, entrylo0, entrylo1, index, random
    );

    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, tlb_type,
        input  tlbp_index_in, tlbr_entryhi_in, tlbr_pagemask_in,
        input  tlbr_entrylo0_in, tlbr_entrylo1_in, tlb_exc, exc_vaddr,
        output mfc0_rdata, entryhi, pagemask, entrylo0, entrylo1, index, random
    );
endinterface

// File: rtl/cp0_tlb_regs.sv
// cp0_tlb_regs
//   CP0 register slice holding the MMU-facing state (Index, Random,
//   EntryLo0/1, PageMask, Wired, BadVAddr, EntryHi). Services MTC0/MFC0,
//   captures TLBP/TLBR results, records TLB-exception addresses and runs
//   the Random replacement counter feeding TLBWR.
//
//   Parameter TLB_WIDTH : index width, TLB holds 2^TLB_WIDTH entries.
//   Ports:
//     clk    : clock
//     resetn : asynchronous active-low reset
//     bus    : cp0_tlb_regs_if.slave (see interface header)
//
//   Build option CP0_WIRED_EN: when defined, Wired (CP0 reg 6) exists and
//   bounds the Random counter from below; when undefined Wired reads 0 and
//   Random counts max..0 and wraps.
module cp0_tlb_regs #(
    parameter int unsigned TLB_WIDTH = 5
) (
    input  logic          clk,
    input  logic          resetn,
    cp0_tlb_regs_if.slave bus
);

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_PAGEMASK = 5'd5;
`ifdef CP0_WIRED_EN
    localparam logic [4:0] REG_WIRED    = 5'd6;
`endif
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;

    // TLBWI/TLBWR change no state here; the TLB consumes index/random directly.
    localparam logic [2:0] TLB_OP_TLBP  = 3'b001;
    localparam logic [2:0] TLB_OP_TLBR  = 3'b010;

    localparam logic [31:0] IDX_LOW_MASK  = 32'((64'd1 << TLB_WIDTH) - 64'd1);
    localparam logic [31:0] IDX_P_MASK    = 32'h8000_0000;
    localparam logic [31:0] ELO_MASK      = 32'h03FF_FFFF;
    localparam logic [31:0] PMASK_MASK    = 32'h1FFF_E000;
    localparam logic [31:0] EHI_MASK      = 32'hFFFF_E0FF;
    localparam logic [31:0] EHI_VPN2_MASK = 32'hFFFF_E000;

    localparam logic [TLB_WIDTH-1:0] RAND_MAX = '1;
    localparam logic [TLB_WIDTH-1:0] RAND_ONE = TLB_WIDTH'(1);

    logic [31:0] index_q,    index_d;
    logic [31:0] entrylo0_q, entrylo0_d;
    logic [31:0] entrylo1_q, entrylo1_d;
    logic [31:0] pagemask_q, pagemask_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] entryhi_q,  entryhi_d;
    logic [TLB_WIDTH-1:0] random_q, random_d;
`ifdef CP0_WIRED_EN
    logic [TLB_WIDTH-1:0] wired_q,  wired_d;
    logic                 wired_wr;
`endif
    logic [31:0] mfc0_rdata_c;

    // Next-state for the software-visible registers.
    // Later assignments override earlier ones: MTC0 < TLBP/TLBR < tlb_exc.
    always_comb begin
        index_d    = index_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        pagemask_d = pagemask_q;
        badvaddr_d = badvaddr_q;
        entryhi_d  = entryhi_q;
`ifdef CP0_WIRED_EN
        wired_d    = wired_q;
        wired_wr   = 1'b0;
`endif

        if (bus.mtc0_we) begin
            case (bus.mtc0_addr)
                // Index write leaves the probe-failure bit alone.
                REG_INDEX:    index_d    = (index_q & ~IDX_LOW_MASK)
                                         | (bus.mtc0_wdata & IDX_LOW_MASK);
                REG_ENTRYLO0: entrylo0_d = bus.mtc0_wdata & ELO_MASK;
                REG_ENTRYLO1: entrylo1_d = bus.mtc0_wdata & ELO_MASK;
                REG_PAGEMASK: pagemask_d = bus.mtc0_wdata & PMASK_MASK;
                REG_ENTRYHI:  entryhi_d  = bus.mtc0_wdata & EHI_MASK;
`ifdef CP0_WIRED_EN
                REG_WIRED: begin
                    wired_d  = bus.mtc0_wdata[TLB_WIDTH-1:0];
                    wired_wr = 1'b1;
                end
`endif
                default: ;
            endcase
        end

        case (bus.tlb_type)
            TLB_OP_TLBP: index_d = bus.tlbp_index_in & (IDX_P_MASK | IDX_LOW_MASK);
            TLB_OP_TLBR: begin
                entryhi_d  = bus.tlbr_entryhi_in  & EHI_MASK;
                pagemask_d = bus.tlbr_pagemask_in & PMASK_MASK;
                entrylo0_d = bus.tlbr_entrylo0_in & ELO_MASK;
                entrylo1_d = bus.tlbr_entrylo1_in & ELO_MASK;
            end
            default: ;
        endcase

        // Exception loads VPN2 from the faulting address, keeps the current ASID.
        if (bus.tlb_exc) begin
            badvaddr_d = bus.exc_vaddr;
            entryhi_d  = (bus.exc_vaddr & EHI_VPN2_MASK) | (entryhi_q & ~EHI_VPN2_MASK);
        end
    end

    // Random replacement counter.
    always_comb begin
        random_d = random_q - RAND_ONE;
`ifdef CP0_WIRED_EN
        // Reload keeps Random inside [Wired, max]; a Wired write restarts it.
        if (wired_wr || (random_q == wired_q) || (random_q == '0)) begin
            random_d = RAND_MAX;
        end
`else
        if (random_q == '0) begin
            random_d = RAND_MAX;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q    <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            pagemask_q <= '0;
            badvaddr_q <= '0;
            entryhi_q  <= '0;
            random_q   <= RAND_MAX;
`ifdef CP0_WIRED_EN
            wired_q    <= '0;
`endif
        end else begin
            index_q    <= index_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            pagemask_q <= pagemask_d;
            badvaddr_q <= badvaddr_d;
            entryhi_q  <= entryhi_d;
            random_q   <= random_d;
`ifdef CP0_WIRED_EN
            wired_q    <= wired_d;
`endif
        end
    end

    // MFC0 read mux; no bypass of same-cycle writes.
    always_comb begin
        mfc0_rdata_c = '0;
        case (bus.mfc0_addr)
            REG_INDEX:    mfc0_rdata_c = index_q;
            REG_RANDOM:   mfc0_rdata_c = 32'(random_q);
            REG_ENTRYLO0: mfc0_rdata_c = entrylo0_q;
            REG_ENTRYLO1: mfc0_rdata_c = entrylo1_q;
            REG_PAGEMASK: mfc0_rdata_c = pagemask_q;
`ifdef CP0_WIRED_EN
            REG_WIRED:    mfc0_rdata_c = 32'(wired_q);
`endif
            REG_BADVADDR: mfc0_rdata_c = badvaddr_q;
            REG_ENTRYHI:  mfc0_rdata_c = entryhi_q;
            default:      mfc0_rdata_c = '0;
        endcase
    end

    assign bus.mfc0_rdata = mfc0_rdata_c;
    assign bus.entryhi    = entryhi_q;
    assign bus.pagemask   = pagemask_q;
    assign bus.entrylo0   = entrylo0_q;
    assign bus.entrylo1   = entrylo1_q;
    assign bus.index      = index_q;
    assign bus.random     = 32'(random_q);

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Testbench for cp0_tlb_regs: directed scenarios plus randomized traffic
// checked against a register-file model indexed by CP0 register number.
module tb_cp0_tlb_regs;

    localparam int unsigned TLB_WIDTH = 5;
    localparam int unsigned RMAX      = 31;
`ifdef CP0_WIRED_EN
    localparam bit WIRED_EN = 1'b1;
`else
    localparam bit WIRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    cp0_tlb_regs_if bus();

    cp0_tlb_regs #(.TLB_WIDTH(TLB_WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural value of each CP0 number, plus Random.
    logic [31:0] m_reg [32];
    int unsigned m_random;

    function automatic logic [31:0] wr_mask(input int unsigned r);
        case (r)
            0:       return 32'h0000_001F;
            2, 3:    return 32'h03FF_FFFF;
            5:       return 32'h1FFF_E000;
            6:       return WIRED_EN ? 32'h0000_001F : 32'h0000_0000;
            10:      return 32'hFFFF_E0FF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int unsigned r);
        if (r == 1) return 32'(m_random);
        return m_reg[r];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_random = RMAX;
    endfunction

    // One clock edge worth of architectural effect from the current inputs.
    function automatic void model_step();
        logic [31:0] nx [32];
        int unsigned nr;
        int unsigned a;
        nx = m_reg;
        a  = int'(bus.mtc0_addr);
        if (bus.mtc0_we)
            nx[a] = (m_reg[a] & ~wr_mask(a)) | (bus.mtc0_wdata & wr_mask(a));
        if (bus.tlb_type == 3'b001)
            nx[0] = bus.tlbp_index_in & 32'h8000_001F;
        if (bus.tlb_type == 3'b010) begin
            nx[10] = bus.tlbr_entryhi_in  & 32'hFFFF_E0FF;
            nx[5]  = bus.tlbr_pagemask_in & 32'h1FFF_E000;
            nx[2]  = bus.tlbr_entrylo0_in & 32'h03FF_FFFF;
            nx[3]  = bus.tlbr_entrylo1_in & 32'h03FF_FFFF;
        end
        if (bus.tlb_exc) begin
            nx[8]  = bus.exc_vaddr;
            nx[10] = {bus.exc_vaddr[31:13], m_reg[10][12:0]};
        end
        if (WIRED_EN && bus.mtc0_we && a == 6)
            nr = RMAX;
        else if (m_random == 0 || (WIRED_EN && m_random == m_reg[6]))
            nr = RMAX;
        else
            nr = m_random - 1;
        m_reg    = nx;
        m_random = nr;
    endfunction

    task automatic idle_inputs();
        bus.mtc0_we          = 1'b0;
        bus.mtc0_addr        = 5'd0;
        bus.mtc0_wdata       = 32'h0;
        bus.tlb_type         = 3'b000;
        bus.tlbp_index_in    = 32'h0;
        bus.tlbr_entryhi_in  = 32'h0;
        bus.tlbr_pagemask_in = 32'h0;
        bus.tlbr_entrylo0_in = 32'h0;
        bus.tlbr_entrylo1_in = 32'h0;
        bus.tlb_exc          = 1'b0;
        bus.exc_vaddr        = 32'h0;
    endtask

    // Advance one edge; model follows the inputs present at that edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        bus.mfc0_addr = r;
        #1;
        v = bus.mfc0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        idle_inputs();
        bus.mtc0_we    = 1'b1;
        bus.mtc0_addr  = r;
        bus.mtc0_wdata = d;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        resetn = 1'b0;
        idle_inputs();
        bus.mfc0_addr = 5'd0;
        model_reset();
        #12;
        for (int r = 0; r < 32; r++) begin
            read_reg(5'(r), v);
            checks++;
            if (v !== model_read(r)) begin
                errors++;
                $display("FAIL reset_read r%0d: got %h expected %h", r, v, model_read(r));
            end
        end
        checks++;
        if (bus.random !== 32'd31) begin
            errors++;
            $display("FAIL reset_random_out: got %h expected %h", bus.random, 32'd31);
        end
        checks++;
        if ({bus.entryhi, bus.pagemask, bus.entrylo0, bus.entrylo1, bus.index} !== 160'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.entryhi, bus.pagemask, bus.entrylo0, bus.entrylo1, bus.index});
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        read_reg(5'd1, v);
        checks++;
        if (v !== 32'd30) begin
            errors++;
            $display("FAIL reset_first_decrement: got %h expected %h", v, 32'd30);
        end
    endtask

    task automatic test_masks();
        logic [31:0] v;
        mtc0(5'd10, 32'hFFFF_FFFF);
        read_reg(5'd10, v);
        checks++;
        if (v !== 32'hFFFF_E0FF) begin
            errors++; $display("FAIL mask_entryhi: got %h expected %h", v, 32'hFFFF_E0FF);
        end
        mtc0(5'd2, 32'hFFFF_FFFF);
        read_reg(5'd2, v);
        checks++;
        if (v !== 32'h03FF_FFFF) begin
            errors++; $display("FAIL mask_entrylo0: got %h expected %h", v, 32'h03FF_FFFF);
        end
        mtc0(5'd3, 32'hFFFF_FFFF);
        read_reg(5'd3, v);
        checks++;
        if (v !== 32'h03FF_FFFF) begin
            errors++; $display("FAIL mask_entrylo1: got %h expected %h", v, 32'h03FF_FFFF);
        end
        mtc0(5'd5, 32'hFFFF_FFFF);
        read_reg(5'd5, v);
        checks++;
        if (v !== 32'h1FFF_E000) begin
            errors++; $display("FAIL mask_pagemask: got %h expected %h", v, 32'h1FFF_E000);
        end
        mtc0(5'd8, 32'hDEAD_BEEF);
        read_reg(5'd8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL badvaddr_readonly: got %h expected %h", v, 32'h0);
        end
        mtc0(5'd1, 32'h0000_0003);
        read_reg(5'd1, v);
        checks++;
        if (v !== model_read(1)) begin
            errors++; $display("FAIL random_readonly: got %h expected %h", v, model_read(1));
        end
        mtc0(5'd6, 32'hFFFF_FFFF);
        read_reg(5'd6, v);
        checks++;
        if (v !== (WIRED_EN ? 32'h0000_001F : 32'h0)) begin
            errors++;
            $display("FAIL wired_write: got %h expected %h", v, WIRED_EN ? 32'h0000_001F : 32'h0);
        end
        mtc0(5'd4, 32'hFFFF_FFFF);
        read_reg(5'd4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL unimplemented_read: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_no_bypass();
        logic [31:0] v;
        mtc0(5'd3, 32'h0000_1234);
        bus.mtc0_we    = 1'b1;
        bus.mtc0_addr  = 5'd3;
        bus.mtc0_wdata = 32'h0000_5678;
        read_reg(5'd3, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            errors++; $display("FAIL no_bypass_old: got %h expected %h", v, 32'h0000_1234);
        end
        tick();
        idle_inputs();
        read_reg(5'd3, v);
        checks++;
        if (v !== 32'h0000_5678) begin
            errors++; $display("FAIL no_bypass_new: got %h expected %h", v, 32'h0000_5678);
        end
    endtask

    task automatic test_tlbp_index();
        logic [31:0] v;
        idle_inputs();
        bus.tlb_type      = 3'b001;
        bus.tlbp_index_in = 32'h8000_0000;
        tick();
        idle_inputs();
        read_reg(5'd0, v);
        checks++;
        if (v !== 32'h8000_0000 || bus.index !== 32'h8000_0000) begin
            errors++; $display("FAIL tlbp_probe_miss: got %h/%h expected %h", v, bus.index, 32'h8000_0000);
        end
        mtc0(5'd0, 32'h0000_0003);
        read_reg(5'd0, v);
        checks++;
        if (v !== 32'h8000_0003) begin
            errors++; $display("FAIL index_keeps_p: got %h expected %h", v, 32'h8000_0003);
        end
        bus.tlb_type      = 3'b001;
        bus.tlbp_index_in = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        checks++;
        if (bus.index !== 32'h8000_001F) begin
            errors++; $display("FAIL tlbp_mask: got %h expected %h", bus.index, 32'h8000_001F);
        end
        bus.tlb_type         = 3'b011;
        bus.tlbr_entryhi_in  = 32'h1111_1111;
        tick();
        bus.tlb_type         = 3'b100;
        tick();
        idle_inputs();
        checks++;
        if (bus.index !== 32'h8000_001F || bus.entryhi !== m_reg[10]) begin
            errors++; $display("FAIL tlbw_no_change: got %h/%h expected %h/%h",
                               bus.index, bus.entryhi, 32'h8000_001F, m_reg[10]);
        end
    endtask

    task automatic test_tlbr();
        idle_inputs();
        bus.tlb_type         = 3'b010;
        bus.tlbr_entryhi_in  = 32'h1234_60AB;
        bus.tlbr_pagemask_in = 32'h0000_6000;
        bus.tlbr_entrylo0_in = 32'h0000_1047;
        bus.tlbr_entrylo1_in = 32'hFC00_1047;
        tick();
        idle_inputs();
        checks++;
        if (bus.entryhi !== 32'h1234_60AB) begin
            errors++; $display("FAIL tlbr_entryhi: got %h expected %h", bus.entryhi, 32'h1234_60AB);
        end
        checks++;
        if (bus.pagemask !== 32'h0000_6000) begin
            errors++; $display("FAIL tlbr_pagemask: got %h expected %h", bus.pagemask, 32'h0000_6000);
        end
        checks++;
        if (bus.entrylo0 !== 32'h0000_1047) begin
            errors++; $display("FAIL tlbr_entrylo0: got %h expected %h", bus.entrylo0, 32'h0000_1047);
        end
        checks++;
        if (bus.entrylo1 !== 32'h0000_1047) begin
            errors++; $display("FAIL tlbr_entrylo1: got %h expected %h", bus.entrylo1, 32'h0000_1047);
        end
    endtask

    task automatic test_exc_priority();
        logic [31:0] v;
        mtc0(5'd10, 32'h0000_0042);
        bus.mtc0_we    = 1'b1;
        bus.mtc0_addr  = 5'd10;
        bus.mtc0_wdata = 32'h0;
        bus.tlb_exc    = 1'b1;
        bus.exc_vaddr  = 32'h7FFF_F123;
        tick();
        idle_inputs();
        read_reg(5'd8, v);
        checks++;
        if (v !== 32'h7FFF_F123) begin
            errors++; $display("FAIL exc_badvaddr: got %h expected %h", v, 32'h7FFF_F123);
        end
        read_reg(5'd10, v);
        checks++;
        if (v !== 32'h7FFF_E042) begin
            errors++; $display("FAIL exc_entryhi: got %h expected %h", v, 32'h7FFF_E042);
        end
    endtask

    task automatic test_random_counter();
        int  prev;
        bit  saw_reload = 1'b0;
        int  floor_val  = 0;
`ifdef CP0_WIRED_EN
        floor_val = 8;
        mtc0(5'd6, 32'd8);
        checks++;
        if (bus.random !== 32'd31) begin
            errors++; $display("FAIL wired_reload: got %h expected %h", bus.random, 32'd31);
        end
`endif
        prev = int'(bus.random);
        for (int n = 0; n < 40; n++) begin
            idle_inputs();
            tick();
            checks++;
            if (bus.random !== 32'(m_random) || int'(bus.random) < floor_val) begin
                errors++; $display("FAIL random_step%0d: got %h expected %h", n, bus.random, m_random);
            end
            if (prev == floor_val) begin
                saw_reload = 1'b1;
                checks++;
                if (bus.random !== 32'd31) begin
                    errors++; $display("FAIL random_wrap: got %h expected %h", bus.random, 32'd31);
                end
            end
            prev = int'(bus.random);
        end
        checks++;
        if (!saw_reload) begin
            errors++; $display("FAIL random_reached_floor: got 0 expected 1");
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 8))
            0: return 5'd0;  1: return 5'd1;  2: return 5'd2;
            3: return 5'd3;  4: return 5'd5;  5: return 5'd6;
            6: return 5'd8;  7: return 5'd10;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_random_traffic();
        logic [31:0] v;
        int unsigned ra;
        for (int n = 0; n < 300; n++) begin
            bus.mtc0_we          = ($urandom_range(0, 2) != 0);
            bus.mtc0_addr        = pick_reg();
            bus.mtc0_wdata       = $urandom();
            bus.tlb_type         = 3'($urandom_range(0, 7));
            bus.tlbp_index_in    = $urandom();
            bus.tlbr_entryhi_in  = $urandom();
            bus.tlbr_pagemask_in = $urandom();
            bus.tlbr_entrylo0_in = $urandom();
            bus.tlbr_entrylo1_in = $urandom();
            bus.tlb_exc          = ($urandom_range(0, 5) == 0);
            bus.exc_vaddr        = $urandom();
            if (bus.tlb_exc && bus.tlb_type == 3'b010) bus.tlb_type = 3'b000;
            ra = $urandom_range(0, 31);
            read_reg(5'(ra), v);
            checks++;
            if (v !== model_read(ra)) begin
                errors++; $display("FAIL rnd_mfc0 n%0d r%0d: got %h expected %h", n, ra, v, model_read(ra));
            end
            tick();
            checks++;
            if (bus.entryhi !== m_reg[10] || bus.pagemask !== m_reg[5]) begin
                errors++; $display("FAIL rnd_ehi_pm n%0d: got %h/%h expected %h/%h",
                                   n, bus.entryhi, bus.pagemask, m_reg[10], m_reg[5]);
            end
            checks++;
            if (bus.entrylo0 !== m_reg[2] || bus.entrylo1 !== m_reg[3]) begin
                errors++; $display("FAIL rnd_elo n%0d: got %h/%h expected %h/%h",
                                   n, bus.entrylo0, bus.entrylo1, m_reg[2], m_reg[3]);
            end
            checks++;
            if (bus.index !== m_reg[0] || bus.random !== 32'(m_random)) begin
                errors++; $display("FAIL rnd_idx_rand n%0d: got %h/%h expected %h/%h",
                                   n, bus.index, bus.random, m_reg[0], m_random);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        mtc0(5'd10, 32'h5555_0011);
        checks++;
        if (bus.entryhi !== 32'h5555_0011) begin
            errors++; $display("FAIL pre_reset_entryhi: got %h expected %h", bus.entryhi, 32'h5555_0011);
        end
        bus.mtc0_we       = 1'b1;
        bus.mtc0_addr     = 5'd10;
        bus.mtc0_wdata    = 32'hABCD_E0FF;
        bus.tlb_type      = 3'b001;
        bus.tlbp_index_in = 32'h8000_0005;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.entryhi !== 32'h0 || bus.index !== 32'h0 || bus.random !== 32'd31) begin
            errors++; $display("FAIL async_reset: got %h/%h/%h expected 0/0/1f",
                               bus.entryhi, bus.index, bus.random);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.entryhi !== 32'h0 || bus.index !== 32'h0) begin
            errors++; $display("FAIL reset_discards_op: got %h/%h expected 0/0", bus.entryhi, bus.index);
        end
        idle_inputs();
        resetn = 1'b1;
        tick();
        checks++;
        if (bus.random !== 32'd30 || bus.entryhi !== 32'h0) begin
            errors++; $display("FAIL post_reset: got %h/%h expected 1e/0", bus.random, bus.entryhi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_masks();
        test_no_bypass();
        test_tlbp_index();
        test_tlbr();
        test_exc_priority();
        test_random_counter();
        test_random_traffic();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_tlb_regs.md
# cp0_tlb_regs

CP0 register slice that owns the MMU-facing coprocessor-0 state: Index, Random, EntryLo0, EntryLo1, PageMask, Wired, BadVAddr and EntryHi. It sits directly upstream of the TLB array. It drives the TLB's EntryHi/PageMask/EntryLo/Index/Random inputs and captures TLBP/TLBR results back from it. It also services MTC0/MFC0 from the M stage and records TLB-exception addresses.

## Interface
Parameters:
- `TLB_WIDTH`, 5: index width. The TLB has 2^TLB_WIDTH entries.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `resetn` in 1: async active-low reset.
- `mtc0_we` in 1: MTC0 write strobe.
- `mtc0_addr` in 5: CP0 register number for the write.
- `mtc0_wdata` in 32: write data.
- `mfc0_addr` in 5: CP0 register number for the read.
- `mfc0_rdata` out 32: read data (combinational from registers).
- `tlb_type` in 3: M-stage TLB op. 001 TLBP, 010 TLBR, 011 TLBWI, 100 TLBWR, other = none.
- `tlbp_index_in` in 32: Index result from the TLB during TLBP.
- `tlbr_entryhi_in`, `tlbr_pagemask_in`, `tlbr_entrylo0_in`, `tlbr_entrylo1_in` in 32 each: TLBR results from the TLB.
- `tlb_exc` in 1: TLB refill/invalid/modified exception committing this cycle.
- `exc_vaddr` in 32: faulting virtual address.
- `entryhi`, `pagemask`, `entrylo0`, `entrylo1`, `index`, `random` out 32 each: registered values driven to the TLB.

## Operation
- Register numbers: 0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 5 PageMask, 6 Wired, 8 BadVAddr, 10 EntryHi.
- MFC0 of any other number returns 0.
- MTC0 write masks:
  - Index: only [TLB_WIDTH-1:0]; the P bit [31] is untouched.
  - EntryLo0/1: [25:0]; [31:26] read 0.
  - PageMask: [28:13].
  - EntryHi: [31:13] and [7:0].
  - Wired: [TLB_WIDTH-1:0].
  - Random and BadVAddr: read-only, writes ignored.
- TLBP: Index <= `tlbp_index_in` masked to bit 31 and [TLB_WIDTH-1:0].
- TLBR: EntryHi, PageMask, EntryLo0 and EntryLo1 <= their `tlbr_*_in` values, with the same masks as MTC0.
- TLBWI/TLBWR: no register change. The TLB consumes `index`/`random` that cycle.
- tlb_exc: BadVAddr <= `exc_vaddr`; EntryHi[31:13] <= `exc_vaddr[31:13]`. EntryHi ASID [7:0] is preserved.
- Random counter:
  - Each cycle: if Random == Wired, or Random == 0, it reloads to 2^TLB_WIDTH-1; otherwise it decrements by 1.
  - MTC0 to Wired reloads Random to 2^TLB_WIDTH-1 in the same edge.
  - Random is therefore always in [Wired, max].
- Priority when several events hit the same register on one edge: tlb_exc > TLBR/TLBP > MTC0.
  - A Wired write coinciding with a normal decrement uses the reload.
- Reset values:
  - Random = 2^TLB_WIDTH-1.
  - All other registers, all outputs and `mfc0_rdata` source = 0.

## Timing
- All updates land on the rising edge of `clk`. Outputs are direct register outputs, one cycle after the causing event.
- No MFC0 bypass: a read in the same cycle as a write to the same register returns the old value.
- `resetn` is asserted asynchronously and forces reset values immediately. Deassertion is sampled on `clk`. Reset in the middle of any op discards that op's update.
- TLBP/TLBR results must be valid in the same cycle `tlb_type` is asserted. Capture happens at that edge.

## Configuration
- `CP0_WIRED_EN` defined:
  - The Wired register exists at number 6 with the reload behaviour above.
- Undefined:
  - Wired reads 0 and writes are ignored.
  - Random wraps max -> 0 -> max, reloading only when it reaches 0.

## Test plan
- Reset, then MFC0 each number -> Random 31, all others 0; `random` output 31. Next cycle Random reads 30.
- MTC0 EntryHi 0xFFFF_FFFF -> reads 0xFFFF_E0FF. MTC0 EntryLo0 0xFFFF_FFFF -> reads 0x03FF_FFFF. MTC0 PageMask 0xFFFF_FFFF -> reads 0x1FFF_E000.
- With `CP0_WIRED_EN`, MTC0 Wired 8 -> Random = 31 next cycle. It counts down to 8, reloads to 31 on the following edge, and never reads below 8.
- TLBP with `tlbp_index_in` = 0x8000_0000 -> Index reads 0x8000_0000. A later MTC0 Index 0x3 -> reads 0x8000_0003, with the P bit kept.
- TLBR with inputs 0x1234_60AB / 0x0000_6000 / 0x0000_1047 / 0xFC00_1047 -> EntryHi 0x1234_60AB, PageMask 0x0000_6000, EntryLo0 0x0000_1047, EntryLo1 0x0000_1047.
- EntryHi = 0x0000_0042, then tlb_exc with `exc_vaddr` 0x7FFF_F123 in the same cycle as MTC0 EntryHi 0 -> BadVAddr 0x7FFF_F123, EntryHi 0x7FFF_E042, because the exception wins.
